tone_burst_generator: RTL and testbench
=======================================

Name: tone_burst_generator

Overview:
- Tone burst state machine that consumes the configuration outputs of the tone burst register bank and drives the physical burst output.
- Configuration inputs: pulse_count, burst_count, duty_cycle, inter_burst_delay, pulse_period, enable, trigger.
- Generates burst_count bursts of pulse_count PWM pulses, separated by inter_burst_delay idle cycles.
- Returns a status word that feeds the register bank's status_inputs.

Parameters:
DATA_WIDTH, 32, width of all configuration inputs and the status word
DUTY_BITS, 10, duty scale exponent; full scale is 2^DUTY_BITS (1024)

Ports:
clk  input  1  clock
rst_n  input  1  reset, synchronous, active-low
enable  input  1  global enable; low aborts any activity
trigger  input  1  start request (single-cycle pulse from register bank)
pulse_count  input  DATA_WIDTH  pulses per burst
burst_count  input  DATA_WIDTH  bursts per run
duty_cycle  input  DATA_WIDTH  high fraction, out of 2^DUTY_BITS
inter_burst_delay  input  DATA_WIDTH  idle cycles between bursts
pulse_period  input  DATA_WIDTH  cycles per pulse
burst_out  output  1  tone burst waveform
busy  output  1  high in PULSE or GAP
done  output  1  one-cycle pulse at run completion
status  output  DATA_WIDTH  status word to register bank status_inputs

Behaviour:
- Reset: rst_n low at a clk edge forces the following:
  - state IDLE; all counters and shadow registers 0.
  - burst_out=0, busy=0, done=0, status=0.
  - Reset mid-run terminates the run immediately; no done pulse.
- States: IDLE, PULSE, GAP, DONE. State encoding: IDLE=0, PULSE=1, GAP=2, DONE=3.
- Start: in IDLE, trigger=1 and enable=1 sampled at edge T.
  - If pulse_count, burst_count or pulse_period is 0: stay IDLE, set error sticky.
  - Otherwise:
    - Latch all configuration into shadow registers; later input changes do not affect the run.
    - Clear the done, error and aborted stickies and the completed count.
    - Enter PULSE with phase=0, pulse_idx=0, burst_idx=0.
- Trigger handling:
  - Ignored outside IDLE.
  - Ignored in IDLE when enable=0.
  - Not queued.
- High time, computed once at start:
  - duty_c = min(duty_cycle, 2^DUTY_BITS).
  - high_time = (pulse_period * duty_c) >> DUTY_BITS.
  - Use a 2*DATA_WIDTH-bit product; no truncation before the shift.
  - duty_c=0 gives a permanently low output; duty_c=2^DUTY_BITS gives a permanently high output.
- PULSE:
  - phase counts 0..period-1.
  - burst_out = (state==PULSE) && (phase < high_time); decoded only from registered state, phase and shadow values.
  - First high cycle is the cycle immediately after edge T.
  - At phase==period-1, phase wraps to 0, then:
    - If not the last pulse: pulse_idx++.
    - If the last pulse and not the last burst: burst_idx++, pulse_idx=0, completed++. Go to GAP if delay>0, otherwise stay in PULSE (back-to-back bursts).
    - If the last pulse of the last burst: completed++, go to DONE.
- GAP:
  - burst_out=0 for exactly inter_burst_delay cycles.
  - Then PULSE with phase=0.
- DONE:
  - Lasts one cycle with done=1 and the done sticky set.
  - Then IDLE.
- Abort: enable=0 sampled in PULSE, GAP or DONE.
  - Next state IDLE; burst_out=0 from the next cycle.
  - Set aborted sticky; no done pulse.
- busy = (state==PULSE || state==GAP).
- Run length: total busy cycles = burst_count*pulse_count*period + (burst_count-1)*delay.
- status word, registered, updated every cycle:
  - [0] busy.
  - [1] done sticky.
  - [2] error sticky.
  - [3] aborted sticky.
  - [5:4] state encoding.
  - [15:6] 0.
  - [31:16] completed bursts, saturating at 16'hFFFF.
  - Bits above [15] are present only when DATA_WIDTH allows.
- Simultaneous events: abort (enable=0) takes priority over counter transitions.

Test Plan:
- Default-equivalent config (10 pulses, 5 bursts, duty 512, delay 1000, period 100), trigger at edge T:
  - burst_out high 50 / low 50 cycles per pulse.
  - busy high for 9000 cycles.
  - done=1 in the following cycle; status[31:16]=5, status[1]=1.
- period=4, duty=256, 3 pulses, 1 burst → burst_out pattern 1000 1000 1000; busy for 12 cycles.
- duty=2000 (clamped), period=8, 2 pulses, 2 bursts, delay=0 → burst_out high 32 consecutive cycles, no gap.
- pulse_count=0 with trigger → remains IDLE, busy=0, status[2]=1; next valid trigger clears status[2].
- enable dropped during the 2nd burst → burst_out=0 and IDLE from the next cycle, status[3]=1, done never pulses.
- Trigger during GAP, and config changed mid-run → both ignored; waveform matches the originally latched config.

Source files
------------

// File: rtl/tone_burst_generator.sv
// Tone burst engine: burst_count bursts of pulse_count PWM pulses with idle gaps,
// driven from shadowed configuration and reporting a status word to the register bank.
module tone_burst_generator #(
   parameter int DATA_WIDTH = 32,
   parameter int DUTY_BITS  = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  trigger,
   input  logic [DATA_WIDTH-1:0] pulse_count,
   input  logic [DATA_WIDTH-1:0] burst_count,
   input  logic [DATA_WIDTH-1:0] duty_cycle,
   input  logic [DATA_WIDTH-1:0] inter_burst_delay,
   input  logic [DATA_WIDTH-1:0] pulse_period,
   output logic                  burst_out,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] status
);

   typedef enum logic [1:0] {IDLE = 2'd0, PULSE = 2'd1, GAP = 2'd2, DONE = 2'd3} state_t;

   localparam logic [DATA_WIDTH-1:0] ONE       = DATA_WIDTH'(1);
   localparam logic [DATA_WIDTH-1:0] DUTY_FULL = DATA_WIDTH'(1) << DUTY_BITS;

   state_t                  state_q, state_d;
   logic [DATA_WIDTH-1:0]   phase_q, phase_d;
   logic [DATA_WIDTH-1:0]   pulse_idx_q, pulse_idx_d;
   logic [DATA_WIDTH-1:0]   burst_idx_q, burst_idx_d;
   logic [DATA_WIDTH-1:0]   gap_cnt_q, gap_cnt_d;
   logic [DATA_WIDTH-1:0]   pc_q, pc_d, bc_q, bc_d, per_q, per_d, dly_q, dly_d;
   logic [DATA_WIDTH-1:0]   high_q, high_d;
   logic [15:0]             completed_q, completed_d, completed_inc;
   logic                    done_st_q, done_st_d;
   logic                    err_st_q, err_st_d;
   logic                    abt_st_q, abt_st_d;
   logic [DATA_WIDTH-1:0]   status_q, status_d;

   logic [DATA_WIDTH-1:0]   duty_c;
   logic [2*DATA_WIDTH-1:0] product;
   logic [DATA_WIDTH-1:0]   high_time;

   // Full-width product so large periods keep their precision before the shift.
   always_comb begin
      duty_c    = (duty_cycle > DUTY_FULL) ? DUTY_FULL : duty_cycle;
      product   = {{DATA_WIDTH{1'b0}}, pulse_period} * {{DATA_WIDTH{1'b0}}, duty_c};
      high_time = DATA_WIDTH'(product >> DUTY_BITS);
   end

   assign completed_inc = (completed_q == 16'hFFFF) ? completed_q : completed_q + 16'd1;

   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      pulse_idx_d = pulse_idx_q;
      burst_idx_d = burst_idx_q;
      gap_cnt_d   = gap_cnt_q;
      pc_d        = pc_q;
      bc_d        = bc_q;
      per_d       = per_q;
      dly_d       = dly_q;
      high_d      = high_q;
      completed_d = completed_q;
      done_st_d   = done_st_q;
      err_st_d    = err_st_q;
      abt_st_d    = abt_st_q;

      case (state_q)
         IDLE: begin
            if (trigger && enable) begin
               if (pulse_count == '0 || burst_count == '0 || pulse_period == '0) begin
                  err_st_d = 1'b1;
               end else begin
                  pc_d        = pulse_count;
                  bc_d        = burst_count;
                  per_d       = pulse_period;
                  dly_d       = inter_burst_delay;
                  high_d      = high_time;
                  done_st_d   = 1'b0;
                  err_st_d    = 1'b0;
                  abt_st_d    = 1'b0;
                  completed_d = '0;
                  phase_d     = '0;
                  pulse_idx_d = '0;
                  burst_idx_d = '0;
                  state_d     = PULSE;
               end
            end
         end
         PULSE: begin
            if (!enable) begin
               state_d  = IDLE;
               abt_st_d = 1'b1;
            end else if (phase_q == per_q - ONE) begin
               phase_d = '0;
               if (pulse_idx_q != pc_q - ONE) begin
                  pulse_idx_d = pulse_idx_q + ONE;
               end else if (burst_idx_q != bc_q - ONE) begin
                  burst_idx_d = burst_idx_q + ONE;
                  pulse_idx_d = '0;
                  completed_d = completed_inc;
                  // A zero delay keeps the next burst contiguous with this one.
                  if (dly_q != '0) begin
                     state_d   = GAP;
                     gap_cnt_d = '0;
                  end
               end else begin
                  completed_d = completed_inc;
                  done_st_d   = 1'b1;
                  state_d     = DONE;
               end
            end else begin
               phase_d = phase_q + ONE;
            end
         end
         GAP: begin
            if (!enable) begin
               state_d  = IDLE;
               abt_st_d = 1'b1;
            end else if (gap_cnt_q == dly_q - ONE) begin
               phase_d = '0;
               state_d = PULSE;
            end else begin
               gap_cnt_d = gap_cnt_q + ONE;
            end
         end
         default: begin
            state_d = IDLE;
            if (!enable) abt_st_d = 1'b1;
         end
      endcase

      // Status is built from next-state values so it lines up with the state it describes.
      status_d    = '0;
      status_d[0] = (state_d == PULSE) || (state_d == GAP);
      status_d[1] = done_st_d;
      status_d[2] = err_st_d;
      status_d[3] = abt_st_d;
      status_d[5:4] = state_d;
      for (int i = 0; i < 16; i++) begin
         if (16 + i < DATA_WIDTH) status_d[16+i] = completed_d[i];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         phase_q     <= '0;
         pulse_idx_q <= '0;
         burst_idx_q <= '0;
         gap_cnt_q   <= '0;
         pc_q        <= '0;
         bc_q        <= '0;
         per_q       <= '0;
         dly_q       <= '0;
         high_q      <= '0;
         completed_q <= '0;
         done_st_q   <= 1'b0;
         err_st_q    <= 1'b0;
         abt_st_q    <= 1'b0;
         status_q    <= '0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         pulse_idx_q <= pulse_idx_d;
         burst_idx_q <= burst_idx_d;
         gap_cnt_q   <= gap_cnt_d;
         pc_q        <= pc_d;
         bc_q        <= bc_d;
         per_q       <= per_d;
         dly_q       <= dly_d;
         high_q      <= high_d;
         completed_q <= completed_d;
         done_st_q   <= done_st_d;
         err_st_q    <= err_st_d;
         abt_st_q    <= abt_st_d;
         status_q    <= status_d;
      end
   end

   assign burst_out = (state_q == PULSE) && (phase_q < high_q);
   assign busy      = (state_q == PULSE) || (state_q == GAP);
   assign done      = (state_q == DONE);
   assign status    = status_q;

endmodule

// File: tb/tb_tone_burst_generator.sv
// Directed bench for tone_burst_generator: hand-computed waveforms, run lengths and status.
module tb_tone_burst_generator;

   logic        clk = 1'b0;
   logic        rst_n, enable, trigger;
   logic [31:0] pulse_count, burst_count, duty_cycle, inter_burst_delay, pulse_period;
   logic        burst_out, busy, done;
   logic [31:0] status;

   int n_checks = 0;
   int n_errors = 0;

   tone_burst_generator dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .trigger(trigger),
      .pulse_count(pulse_count), .burst_count(burst_count), .duty_cycle(duty_cycle),
      .inter_burst_delay(inter_burst_delay), .pulse_period(pulse_period),
      .burst_out(burst_out), .busy(busy), .done(done), .status(status)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Applies config and a one-cycle trigger; returns at the negedge after the sampling edge.
   task automatic start_run(input int pc, input int bc, input int duty, input int dly, input int per);
      pulse_count = pc; burst_count = bc; duty_cycle = duty;
      inter_burst_delay = dly; pulse_period = per;
      trigger = 1'b1;
      @(negedge clk);
      trigger = 1'b0;
   endtask

   task automatic expect_run(input string tag, input int pc, input int bc, input int dly,
                             input int per, input int hi, input int exp_busy,
                             input bit perturb, output int high_n);
      int bad = 0;
      int busy_n = 0;
      high_n = 0;
      for (int b = 0; b < bc; b++) begin
         for (int p = 0; p < pc; p++) begin
            for (int ph = 0; ph < per; ph++) begin
               if (burst_out !== (ph < hi)) bad++;
               if (busy === 1'b1) busy_n++;
               if (burst_out === 1'b1) high_n++;
               @(negedge clk);
            end
         end
         if (b < bc - 1) begin
            for (int g = 0; g < dly; g++) begin
               if (burst_out !== 1'b0) bad++;
               if (busy === 1'b1) busy_n++;
               if (perturb && g == 0) begin
                  trigger = 1'b1;
                  pulse_count = $urandom_range(1, 7);
                  duty_cycle = $urandom_range(0, 1024);
                  pulse_period = $urandom_range(1, 9);
                  inter_burst_delay = $urandom_range(0, 9);
               end else begin
                  trigger = 1'b0;
               end
               @(negedge clk);
            end
         end
      end
      trigger = 1'b0;
      check({tag, "_wave"}, bad, 0);
      check({tag, "_busy_len"}, busy_n, exp_busy);
      check({tag, "_done"}, done, 1);
      check({tag, "_busy_off"}, busy, 0);
      check({tag, "_completed"}, status[31:16], bc);
      check({tag, "_done_sticky"}, status[1], 1);
      check({tag, "_state_done"}, status[5:4], 3);
      @(negedge clk);
      check({tag, "_done_clr"}, done, 0);
      check({tag, "_state_idle"}, status[5:4], 0);
   endtask

   initial begin
      int high_n;
      int bad;
      rst_n = 1'b0; enable = 1'b0; trigger = 1'b0;
      pulse_count = 0; burst_count = 0; duty_cycle = 0;
      inter_burst_delay = 0; pulse_period = 0;
      repeat (3) @(negedge clk);
      check("rst_out", burst_out, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_status", status, 0);
      rst_n = 1'b1; enable = 1'b1;
      @(negedge clk);

      // 10 pulses x 5 bursts, period 100, half duty, 1000-cycle gaps.
      start_run(10, 5, 512, 1000, 100);
      expect_run("dflt", 10, 5, 1000, 100, 50, 9000, 1'b0, high_n);
      check("dflt_high_total", high_n, 2500);

      // Zero pulse_count is rejected and flagged; the next good start clears the flag.
      start_run(0, 5, 512, 10, 100);
      check("err_busy", busy, 0);
      check("err_flag", status[2], 1);
      check("err_state", status[5:4], 0);
      repeat (3) @(negedge clk);
      check("err_still_idle", busy, 0);
      start_run(3, 1, 256, 0, 4);
      check("err_cleared", status[2], 0);
      expect_run("quarter", 3, 1, 0, 4, 1, 12, 1'b0, high_n);
      check("quarter_high_total", high_n, 3);

      // Duty clamps to full scale; zero delay gives contiguous bursts.
      start_run(2, 2, 2000, 0, 8);
      expect_run("clamp", 2, 2, 0, 8, 8, 32, 1'b0, high_n);
      check("clamp_high_total", high_n, 32);

      // Zero duty keeps the output low for the whole run.
      start_run(1, 1, 0, 0, 5);
      expect_run("zero_duty", 1, 1, 0, 5, 0, 5, 1'b0, high_n);
      check("zero_duty_high", high_n, 0);

      // Trigger in GAP and config changes mid-run have no effect: 6*341>>10 = 1.
      start_run(2, 2, 341, 4, 6);
      pulse_count = 9; pulse_period = 3; duty_cycle = 1000;
      expect_run("latched", 2, 2, 4, 6, 1, 28, 1'b1, high_n);
      check("latched_high_total", high_n, 4);

      // Abort 2 cycles into the second burst (8 pulse cycles + 3 gap cycles before it).
      start_run(2, 3, 512, 3, 4);
      bad = 0;
      for (int c = 0; c < 12; c++) begin
         if (busy !== 1'b1) bad++;
         @(negedge clk);
      end
      check("abort_pre_busy", bad, 0);
      check("abort_pre_out", burst_out, 1);
      enable = 1'b0;
      @(negedge clk);
      check("abort_out", burst_out, 0);
      check("abort_busy", busy, 0);
      check("abort_flag", status[3], 1);
      check("abort_state", status[5:4], 0);
      check("abort_completed", status[31:16], 1);
      check("abort_no_done_sticky", status[1], 0);
      trigger = 1'b1;
      bad = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         trigger = 1'b0;
         if (done !== 1'b0 || busy !== 1'b0) bad++;
      end
      check("abort_quiet", bad, 0);
      enable = 1'b1;
      @(negedge clk);

      // Reset mid-run ends the run at once with everything cleared.
      start_run(4, 4, 512, 2, 10);
      repeat (7) @(negedge clk);
      check("mid_busy", busy, 1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("mid_rst_status", status, 0);
      check("mid_rst_busy", busy, 0);
      bad = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (done !== 1'b0 || burst_out !== 1'b0) bad++;
      end
      check("mid_rst_quiet", bad, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
